// File: rtl/pwm_deadtime.sv
// Dead-time insertion: turns one PWM stream into a non-overlapping high/low gate pair.
// Optional fault shutdown path is compiled in with `define PWM_DT_FAULT_EN.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_cycles,
`ifdef PWM_DT_FAULT_EN
    input  logic                fault,
    input  logic                fault_clr,
    output logic                fault_latched,
`endif
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                dt_active
);

    typedef enum logic [2:0] {
        IDLE,
        HI_ON,
        DT_H2L,
        LO_ON,
        DT_L2H
`ifdef PWM_DT_FAULT_EN
        ,
        FAULT
`endif
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DT_WIDTH-1:0] cnt_reg;
    logic [DT_WIDTH-1:0] cnt_next;
    logic                pwm_hi_reg;
    logic                pwm_lo_reg;
    logic                dt_active_reg;
    logic                cnt_zero;
    logic                in_dead;
    logic                next_dead;
`ifdef PWM_DT_FAULT_EN
    logic                fault_latched_reg;
`endif

    assign cnt_zero  = (cnt_reg == '0);
    assign in_dead   = (state_reg == DT_H2L) || (state_reg == DT_L2H);
    assign next_dead = (state_next == DT_H2L) || (state_next == DT_L2H);

    always_comb begin
        state_next = state_reg;
`ifdef PWM_DT_FAULT_EN
        if (fault) begin
            state_next = FAULT;
        end else if (state_reg == FAULT) begin
            if (fault_clr) begin
                state_next = IDLE;
            end
        end else
`endif
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = pwm_in ? DT_L2H : DT_H2L;
                HI_ON:   if (!pwm_in) state_next = DT_H2L;
                LO_ON:   if (pwm_in) state_next = DT_L2H;
                // A reversal inside the dead window returns straight to the side
                // that was on, since the opposite side never turned on.
                DT_H2L: begin
                    if (pwm_in) begin
                        state_next = HI_ON;
                    end else if (cnt_zero) begin
                        state_next = LO_ON;
                    end
                end
                DT_L2H: begin
                    if (!pwm_in) begin
                        state_next = LO_ON;
                    end else if (cnt_zero) begin
                        state_next = HI_ON;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // dead_cycles is captured only on entry so mid-window changes are ignored.
    always_comb begin
        cnt_next = cnt_reg;
        if (next_dead && (state_next != state_reg)) begin
            cnt_next = dead_cycles;
        end else if (in_dead && !cnt_zero) begin
            cnt_next = cnt_reg - DT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pwm_hi_reg    <= 1'b0;
            pwm_lo_reg    <= 1'b0;
            dt_active_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pwm_hi_reg    <= (state_next == HI_ON);
            pwm_lo_reg    <= (state_next == LO_ON);
            dt_active_reg <= next_dead;
        end
    end

`ifdef PWM_DT_FAULT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched_reg <= 1'b0;
        end else begin
            fault_latched_reg <= (state_next == FAULT);
        end
    end

    assign fault_latched = fault_latched_reg;
`endif

    assign pwm_hi    = pwm_hi_reg;
    assign pwm_lo    = pwm_lo_reg;
    assign dt_active = dt_active_reg;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: driver queues hand-computed outputs, monitor compares each cycle.
// Fault scenarios are included when PWM_DT_FAULT_EN is defined.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pwm_in;
    logic [7:0] dead_cycles;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       dt_active;
    logic       fl_got;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       exp_fl = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic  hi;
        logic  lo;
        logic  dt;
        logic  fl;
        string nm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

`ifdef PWM_DT_FAULT_EN
    logic fault_latched;
    assign fl_got = fault_latched;
`else
    assign fl_got = 1'b0;
`endif

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .dead_cycles  (dead_cycles),
`ifdef PWM_DT_FAULT_EN
        .fault        (fault),
        .fault_clr    (fault_clr),
        .fault_latched(fault_latched),
`endif
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .dt_active    (dt_active)
    );

    // Drive inputs at a falling edge; the expectation is the output after the next rising edge.
    task automatic step(input logic en, input logic pin, input logic [7:0] dc,
                        input logic ehi, input logic elo, input logic edt, input string nm);
        exp_t e;
        enable      = en;
        pwm_in      = pin;
        dead_cycles = dc;
        e.hi = ehi;
        e.lo = elo;
        e.dt = edt;
        e.fl = exp_fl;
        e.nm = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rep(input int n, input logic en, input logic pin, input logic [7:0] dc,
                       input logic ehi, input logic elo, input logic edt, input string nm);
        for (int i = 0; i < n; i++) begin
            step(en, pin, dc, ehi, elo, edt, nm);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                total++;
                if (pwm_hi && pwm_lo) begin
                    bad++;
                    $display("FAIL overlap: got hi=1 lo=1, need at most one side high");
                end
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({pwm_hi, pwm_lo, dt_active, fl_got} !== {e.hi, e.lo, e.dt, e.fl}) begin
                    bad++;
                    $display("FAIL %s: got hi=%0b lo=%0b dt=%0b fl=%0b, need hi=%0b lo=%0b dt=%0b fl=%0b",
                             e.nm, pwm_hi, pwm_lo, dt_active, fl_got, e.hi, e.lo, e.dt, e.fl);
                end
                $display("chk %s: hi=%0b lo=%0b dt=%0b fl=%0b", e.nm, pwm_hi, pwm_lo, dt_active, fl_got);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, need finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst         = 1'b1;
        enable      = 1'b0;
        pwm_in      = 1'b0;
        dead_cycles = 8'd0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({pwm_hi, pwm_lo, dt_active, fl_got} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_state: got %b, need 0000", {pwm_hi, pwm_lo, dt_active, fl_got});
        end
        rst = 1'b0;

        rep(2, 0, 0, 0, 0, 0, 0, "idle_dis");

        // Start into HI_ON with a 2-clock dead window.
        rep(2, 1, 1, 1, 0, 0, 1, "start_dt");
        rep(3, 1, 1, 1, 1, 0, 0, "start_hi");

        // Asynchronous reset mid-HI_ON clears outputs before any edge.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({pwm_hi, pwm_lo, dt_active} !== 3'b000) begin
            bad++;
            $display("FAIL async_rst: got %b, need 000", {pwm_hi, pwm_lo, dt_active});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // dead_cycles=4: pwm_hi rises 5 clocks after the first sampling edge.
        rep(5, 1, 1, 4, 0, 0, 1, "rst_start_dt");
        rep(3, 1, 1, 4, 1, 0, 0, "rst_start_hi");

        // 50% duty, period 20, dead_cycles=3: 4 dead + 6 on per half period.
        for (int p = 0; p < 2; p++) begin
            rep(4, 1, 0, 3, 0, 0, 1, "duty_h2l");
            rep(6, 1, 0, 3, 0, 1, 0, "duty_lo");
            rep(4, 1, 1, 3, 0, 0, 1, "duty_l2h");
            rep(6, 1, 1, 3, 1, 0, 0, "duty_hi");
        end

        // dead_cycles=0: exactly one both-low clock per transition.
        step(1, 0, 0, 0, 0, 1, "dc0_h2l");
        rep(2, 1, 0, 0, 0, 1, 0, "dc0_lo");
        step(1, 1, 0, 0, 0, 1, "dc0_l2h");
        rep(2, 1, 1, 0, 1, 0, 0, "dc0_hi");

        // 3-clock low glitch inside an 8-clock dead time is absorbed.
        rep(3, 1, 0, 8, 0, 0, 1, "glitch_dt");
        rep(3, 1, 1, 8, 1, 0, 0, "glitch_hi");

        // Drop enable in DT_L2H with cnt=2.
        step(1, 0, 0, 0, 0, 1, "pre_drop_dt");
        rep(2, 1, 0, 0, 0, 1, 0, "pre_drop_lo");
        rep(3, 1, 1, 4, 0, 0, 1, "drop_dt");
        rep(3, 0, 1, 4, 0, 0, 0, "en_drop");

        // Raising dead_cycles inside a dead window does not extend it.
        step(1, 0, 2, 0, 0, 1, "dc_change_dt");
        rep(2, 1, 0, 7, 0, 0, 1, "dc_change_dt");
        rep(2, 1, 0, 7, 0, 1, 0, "dc_change_lo");

`ifdef PWM_DT_FAULT_EN
        fault  = 1'b1;
        exp_fl = 1'b1;
        step(1, 0, 1, 0, 0, 0, "flt_entry");
        fault  = 1'b0;
        rep(3, 1, 0, 1, 0, 0, 0, "flt_hold");
        fault     = 1'b1;
        fault_clr = 1'b1;
        step(1, 0, 1, 0, 0, 0, "flt_clr_ignored");
        fault  = 1'b0;
        exp_fl = 1'b0;
        step(1, 0, 1, 0, 0, 0, "flt_clear");
        fault_clr = 1'b0;
        rep(2, 1, 1, 1, 0, 0, 1, "flt_restart_dt");
        step(1, 1, 1, 1, 0, 0, "flt_restart_hi");
`endif

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
